status_collect_arb: RTL and testbench
=====================================

// Module: status_collect_arb
// PURPOSE
//  Parametrised successor to the fixed 4-channel status path. Captures NUM_CH 128-bit status words.
//  Extracts per-channel free-memory and pending-task fields and keeps a one-deep record per channel.
//  A round-robin FSM serialises those records onto ONE write port (wr_start/wr_done handshake) toward the AXI write master.
//  Also computes aggregate busy and threshold flags.
// PARAMETERS
//  NUM_CH      4            number of status channels (1..16)
//  INFO_W      128          width of one status word
//  ADDR_W      32           write address width
//  BASE_ADDR   32'h0000_0000 address of channel 0 record
//  STRIDE      32'h40       byte spacing between channel records
//  THRESH      32'd64       aggregate pending-task threshold
//  TIMEOUT_CYC 1024         max cycles waiting for wr_done
// PORTS
//  ACLK               in   1            clock, all logic rising-edge
//  ARESET             in   1            reset, synchronous, active-high
//  clear_sig          in   1            synchronous clear of records/flags/counters
//  info_in            in   NUM_CH*INFO_W  status words, channel i at [i*INFO_W +: INFO_W]
//  valid_in           in   NUM_CH       per-channel valid strobe
//  out_free_mem       out  NUM_CH*32    latched info[31:0] per channel
//  out_pending_tasks  out  NUM_CH*32    latched info[63:32] per channel
//  out_info_valid     out  NUM_CH       1-cycle pulse when channel fields update
//  upstream_busy      out  1            any record queued or FSM not IDLE
//  threshold_reached  out  1            sum(out_pending_tasks) >= THRESH
//  wr_start           out  1            1-cycle write request pulse
//  wr_addr            out  ADDR_W       BASE_ADDR + ch*STRIDE, held until wr_done/timeout
//  wr_data            out  64           {pending_tasks, free_mem} of granted channel, held likewise
//  wr_done            in   1            write-complete pulse from write master
//  wr_timeout_err     out  1            sticky; set on timeout, cleared by clear_sig
//  drop_cnt           out  16           saturating count of overwritten unsent records
// BEHAVIOUR
//  Reset (ARESET=1): all outputs 0, all queued flags 0, FSM=IDLE, rr pointer=0.
//  Capture: valid_in[i]=1 at edge k -> out_* fields and out_info_valid[i] at k+1; queued[i] set.
//  Overwrite: valid_in[i] while queued[i]=1 and channel i not latched by FSM this cycle -> new data replaces old, drop_cnt+1 (saturate 16'hFFFF).
//  Same-cycle latch + new valid on same channel: FSM takes old record; queued[i] stays 1 with new data; no drop.
//  FSM IDLE: any queued -> ARB.
//  FSM ARB: grant lowest-index queued channel at/after rr pointer (wraps NUM_CH-1 -> 0).
//    Latch addr/data, clear queued[g], -> START.
//  FSM START: wr_start=1 for exactly one cycle -> WAIT; timer=0.
//  FSM WAIT: wr_done -> rr=g+1 (mod NUM_CH), -> IDLE.
//    timer==TIMEOUT_CYC-1 without wr_done -> wr_timeout_err=1, record discarded, rr advance, -> IDLE.
//  wr_done outside WAIT is ignored.
//  Latency: valid_in to wr_start = 3 cycles when FSM idle (capture, ARB, START).
//  threshold_reached: registered; updates 1 cycle after out_pending_tasks.
//    Sum width 32+$clog2(NUM_CH), no overflow; compare unsigned.
//  upstream_busy: combinational OR of queued[] and (state!=IDLE).
//  clear_sig: queued[]=0, out_* fields=0, drop_cnt=0, wr_timeout_err=0, threshold_reached=0 next cycle.
//    An outstanding WAIT write completes normally (not aborted).
//    valid_in in the clear cycle is ignored.
//  ARESET mid-write: FSM to IDLE immediately; wr_addr/wr_data cleared; a late wr_done is ignored.
// STRUCTURE
//  Package status_pkg: INFO_FREE_LSB=0, INFO_PEND_LSB=32, FIELD_W=32, WR_DATA_W=64, FSM state enum {IDLE,ARB,START,WAIT}.
//  Sub-module rr_arbiter (NUM_CH req, rr pointer in, one-hot + index grant out), combinational.
//  Capture/queue logic and FSM stay in top.
// TESTING
//  1 ch0 valid, info[63:0]=64'h0000_0005_0000_1000, wr_done 2 cycles after wr_start
//    -> wr_start at +3, wr_addr=BASE_ADDR, wr_data=64'h5_0000_1000, busy low after done.
//  2 all 4 channels valid same cycle -> four writes in order ch0,ch1,ch2,ch3.
//    Then ch3+ch0 valid -> ch0 served before ch3? no: rr=0 after wrap -> ch0 then ch3.
//  3 ch1 valid twice while FSM stuck in WAIT on ch0 -> drop_cnt=1, second ch1 data written.
//  4 pending fields 20,20,20,4 -> threshold_reached=1; ch3 updates to 3 -> threshold_reached=0.
//  5 wr_done never returned -> wr_timeout_err=1 after TIMEOUT_CYC cycles in WAIT, FSM IDLE.
//    Next queued channel is served.
//  6 ARESET in WAIT, then wr_done pulse -> no wr_start, all outputs 0.
//    clear_sig during WAIT -> write completes, fields zeroed.

Source files
------------

// File: rtl/status_collect_arb_pkg.sv
// Shared field positions and FSM encoding for the status collector.
package status_pkg;

  localparam int INFO_FREE_LSB = 0;
  localparam int INFO_PEND_LSB = 32;
  localparam int FIELD_W       = 32;
  localparam int WR_DATA_W     = 64;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    START,
    WAIT
  } fsm_state_e;

endpackage

// File: rtl/status_collect_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid     = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/status_collect_arb.sv
// Captures per-channel status words, keeps one pending record per channel and
// serialises records onto a single write port with a round-robin FSM.
module status_collect_arb
  import status_pkg::*;
#(
  parameter int                NUM_CH      = 4,
  parameter int                INFO_W      = 128,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_W-1:0] STRIDE      = ADDR_W'(64),
  parameter logic [31:0]       THRESH      = 32'd64,
  parameter int                TIMEOUT_CYC = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      clear_sig,
  input  logic [NUM_CH*INFO_W-1:0]  info_in,
  input  logic [NUM_CH-1:0]         valid_in,
  output logic [NUM_CH*FIELD_W-1:0] out_free_mem,
  output logic [NUM_CH*FIELD_W-1:0] out_pending_tasks,
  output logic [NUM_CH-1:0]         out_info_valid,
  output logic                      upstream_busy,
  output logic                      threshold_reached,
  output logic                      wr_start,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [WR_DATA_W-1:0]      wr_data,
  input  logic                      wr_done,
  output logic                      wr_timeout_err,
  output logic [15:0]               drop_cnt
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = FIELD_W + $clog2(NUM_CH);
  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

  fsm_state_e state, state_next;

  logic [NUM_CH-1:0][FIELD_W-1:0] free_mem, pend_tasks;
  logic [NUM_CH-1:0]              queued, info_valid, latched, dropped;
  logic [NUM_CH-1:0]              grant;
  logic [IDX_W-1:0]               grant_idx, rr_ptr, cur_ch;
  logic                           grant_valid, take, done_ok, timed_out;
  logic [TMR_W-1:0]               timer;
  logic [SUM_W-1:0]               pend_sum;
  logic [16:0]                    drop_sum;

  rr_arbiter #(
    .NUM_CH(NUM_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (queued),
    .ptr        (rr_ptr),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  // A record handed to the FSM this cycle is not a drop even if a new one arrives.
  assign latched = take ? grant : '0;
  assign dropped = valid_in & queued & ~latched & {NUM_CH{~clear_sig}};

  always_comb begin
    drop_sum = {1'b0, drop_cnt};
    pend_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_sum = drop_sum + 17'(dropped[i]);
      pend_sum = pend_sum + SUM_W'(pend_tasks[i]);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || clear_sig) begin
      free_mem          <= '0;
      pend_tasks        <= '0;
      queued            <= '0;
      info_valid        <= '0;
      drop_cnt          <= '0;
      threshold_reached <= 1'b0;
    end else begin
      info_valid <= valid_in;
      queued     <= (queued & ~latched) | valid_in;
      for (int i = 0; i < NUM_CH; i++) begin
        if (valid_in[i]) begin
          free_mem[i]   <= info_in[i*INFO_W + INFO_FREE_LSB +: FIELD_W];
          pend_tasks[i] <= info_in[i*INFO_W + INFO_PEND_LSB +: FIELD_W];
        end
      end
      drop_cnt          <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      threshold_reached <= (pend_sum >= SUM_W'(THRESH));
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr_start   = 1'b0;
    take       = 1'b0;
    done_ok    = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE:  if (|queued) state_next = ARB;
      ARB: begin
        if (grant_valid) begin
          take       = 1'b1;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        wr_start   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (wr_done) begin
          done_ok    = 1'b1;
          state_next = IDLE;
        end else if (timer == TMR_LAST) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write-port datapath; a timeout outranks a simultaneous clear so it is never lost.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rr_ptr         <= '0;
      cur_ch         <= '0;
      timer          <= '0;
      wr_addr        <= '0;
      wr_data        <= '0;
      wr_timeout_err <= 1'b0;
    end else begin
      if (take) begin
        cur_ch  <= grant_idx;
        wr_addr <= BASE_ADDR + ADDR_W'(grant_idx) * STRIDE;
        wr_data <= {pend_tasks[grant_idx], free_mem[grant_idx]};
      end
      if (state == START)     timer <= '0;
      else if (state == WAIT) timer <= timer + TMR_W'(1);
      if (done_ok || timed_out) begin
        rr_ptr  <= (cur_ch == LAST_CH) ? '0 : cur_ch + IDX_W'(1);
        wr_addr <= '0;
        wr_data <= '0;
      end
      if (timed_out)      wr_timeout_err <= 1'b1;
      else if (clear_sig) wr_timeout_err <= 1'b0;
    end
  end

  assign out_free_mem      = free_mem;
  assign out_pending_tasks = pend_tasks;
  assign out_info_valid    = info_valid;
  assign upstream_busy     = (|queued) || (state != IDLE);

endmodule

// File: tb/tb_status_collect_arb.sv
// Directed bench for status_collect_arb: capture, round-robin order, drops,
// threshold, timeout, reset and clear behaviour.
module tb_status_collect_arb;

  localparam int          NUM_CH      = 4;
  localparam int          INFO_W      = 128;
  localparam int          ADDR_W      = 32;
  localparam int          TIMEOUT_CYC = 32;
  localparam logic [31:0] BASE        = 32'h1000_0000;
  localparam logic [31:0] STRIDE      = 32'h40;

  logic                     ACLK = 1'b0;
  logic                     ARESET = 1'b1;
  logic                     clear_sig = 1'b0;
  logic [NUM_CH*INFO_W-1:0] info_in = '0;
  logic [NUM_CH-1:0]        valid_in = '0;
  logic [NUM_CH*32-1:0]     out_free_mem, out_pending_tasks;
  logic [NUM_CH-1:0]        out_info_valid;
  logic                     upstream_busy, threshold_reached, wr_start;
  logic [ADDR_W-1:0]        wr_addr;
  logic [63:0]              wr_data;
  logic                     wr_done = 1'b0;
  logic                     wr_timeout_err;
  logic [15:0]              drop_cnt;

  int checks = 0;
  int failures = 0;

  status_collect_arb #(
    .NUM_CH     (NUM_CH),
    .INFO_W     (INFO_W),
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE),
    .STRIDE     (STRIDE),
    .THRESH     (32'd64),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .ACLK             (ACLK),
    .ARESET           (ARESET),
    .clear_sig        (clear_sig),
    .info_in          (info_in),
    .valid_in         (valid_in),
    .out_free_mem     (out_free_mem),
    .out_pending_tasks(out_pending_tasks),
    .out_info_valid   (out_info_valid),
    .upstream_busy    (upstream_busy),
    .threshold_reached(threshold_reached),
    .wr_start         (wr_start),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_done          (wr_done),
    .wr_timeout_err   (wr_timeout_err),
    .drop_cnt         (drop_cnt)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    tick();
    tick();
    ARESET = 1'b0;
  endtask

  task automatic set_info(input int ch, input logic [31:0] free_v, input logic [31:0] pend_v);
    info_in[ch*INFO_W +: 64] = {pend_v, free_v};
  endtask

  task automatic pulse_valid(input logic [NUM_CH-1:0] mask);
    valid_in = mask;
    tick();
    valid_in = '0;
  endtask

  task automatic wait_start(input string tag, input logic [31:0] exp_addr, input logic [63:0] exp_data);
    int n;
    n = 0;
    while (wr_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 64'(wr_start), 64'd1);
    check({tag, "_addr"}, 64'(wr_addr), 64'(exp_addr));
    check({tag, "_data"}, wr_data, exp_data);
  endtask

  task automatic ack();
    tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
  endtask

  initial begin
    logic [31:0] f;
    logic [31:0] p;
    int          idx;
    int          starts;

    $display("[TB] reset state");
    do_reset();
    check("rst_free", 64'(out_free_mem), 64'd0);
    check("rst_busy", 64'(upstream_busy), 64'd0);
    check("rst_start", 64'(wr_start), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_thr", 64'(threshold_reached), 64'd0);
    check("rst_err", 64'(wr_timeout_err), 64'd0);

    $display("[TB] single channel latency");
    set_info(0, 32'h0000_1000, 32'h0000_0005);
    pulse_valid(4'b0001);
    check("t1_ivalid", 64'(out_info_valid), 64'h1);
    check("t1_free", 64'(out_free_mem[31:0]), 64'h1000);
    check("t1_pend", 64'(out_pending_tasks[31:0]), 64'h5);
    check("t1_busy", 64'(upstream_busy), 64'd1);
    tick();
    check("t1_ivalid_pulse", 64'(out_info_valid), 64'h0);
    check("t1_early_start", 64'(wr_start), 64'd0);
    tick();
    check("t1_start", 64'(wr_start), 64'd1);
    check("t1_addr", 64'(wr_addr), 64'(BASE));
    check("t1_data", wr_data, 64'h0000_0005_0000_1000);
    tick();
    check("t1_start_once", 64'(wr_start), 64'd0);
    tick();
    check("t1_addr_held", 64'(wr_addr), 64'(BASE));
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("t1_busy_done", 64'(upstream_busy), 64'd0);

    $display("[TB] four channels, round-robin order");
    do_reset();
    for (int i = 0; i < NUM_CH; i++) set_info(i, 32'h100 + 32'(i), 32'(i + 1));
    pulse_valid(4'b1111);
    for (int i = 0; i < NUM_CH; i++) begin
      f = 32'h100 + 32'(i);
      p = 32'(i + 1);
      wait_start($sformatf("t2_w%0d", i), BASE + 32'(i) * STRIDE, {p, f});
      ack();
    end
    set_info(0, 32'h200, 32'd7);
    set_info(3, 32'h203, 32'd8);
    pulse_valid(4'b1001);
    wait_start("t2_wrap_ch0", BASE, {32'd7, 32'h200});
    ack();
    wait_start("t2_wrap_ch3", BASE + 32'd3 * STRIDE, {32'd8, 32'h203});
    ack();

    $display("[TB] overwrite while stuck in WAIT");
    set_info(0, 32'h300, 32'd1);
    pulse_valid(4'b0001);
    wait_start("t3_ch0", BASE, {32'd1, 32'h300});
    tick();
    set_info(1, 32'hA1, 32'd2);
    pulse_valid(4'b0010);
    set_info(1, 32'hB1, 32'd3);
    pulse_valid(4'b0010);
    check("t3_drop", 64'(drop_cnt), 64'd1);
    ack();
    wait_start("t3_ch1", BASE + STRIDE, {32'd3, 32'hB1});
    ack();
    check("t3_idle", 64'(upstream_busy), 64'd0);

    $display("[TB] threshold boundary");
    set_info(0, 32'h0, 32'd20);
    set_info(1, 32'h0, 32'd20);
    set_info(2, 32'h0, 32'd20);
    set_info(3, 32'h0, 32'd4);
    pulse_valid(4'b1111);
    check("t4_thr_lag", 64'(threshold_reached), 64'd0);
    tick();
    check("t4_thr_64", 64'(threshold_reached), 64'd1);
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (2 + k) % NUM_CH;
      p = (idx == 3) ? 32'd4 : 32'd20;
      wait_start($sformatf("t4_rr%0d", k), BASE + 32'(idx) * STRIDE, {p, 32'h0});
      ack();
    end
    set_info(3, 32'h0, 32'd3);
    pulse_valid(4'b1000);
    tick();
    check("t4_thr_63", 64'(threshold_reached), 64'd0);
    wait_start("t4_ch3", BASE + 32'd3 * STRIDE, {32'd3, 32'h0});
    ack();

    $display("[TB] write timeout");
    set_info(2, 32'h52, 32'd1);
    set_info(3, 32'h53, 32'd1);
    pulse_valid(4'b1100);
    wait_start("t5_ch2", BASE + 32'd2 * STRIDE, {32'd1, 32'h52});
    for (int n = 0; n < TIMEOUT_CYC; n++) tick();
    check("t5_err_early", 64'(wr_timeout_err), 64'd0);
    check("t5_busy_wait", 64'(upstream_busy), 64'd1);
    tick();
    check("t5_err", 64'(wr_timeout_err), 64'd1);
    wait_start("t5_ch3", BASE + 32'd3 * STRIDE, {32'd1, 32'h53});
    ack();
    check("t5_err_sticky", 64'(wr_timeout_err), 64'd1);
    clear_sig = 1'b1;
    tick();
    clear_sig = 1'b0;
    check("t5_err_clear", 64'(wr_timeout_err), 64'd0);

    $display("[TB] reset during WAIT");
    set_info(1, 32'h61, 32'd2);
    pulse_valid(4'b0010);
    wait_start("t6_ch1", BASE + STRIDE, {32'd2, 32'h61});
    tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("t6_addr", 64'(wr_addr), 64'd0);
    check("t6_data", wr_data, 64'd0);
    check("t6_busy", 64'(upstream_busy), 64'd0);
    check("t6_fields", 64'((out_free_mem == '0) && (out_pending_tasks == '0)), 64'd1);
    starts = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (wr_start) starts++;
    end
    check("t6_no_start", 64'(starts), 64'd0);

    $display("[TB] clear during WAIT");
    set_info(0, 32'h77, 32'd9);
    pulse_valid(4'b0001);
    wait_start("t6c_ch0", BASE, {32'd9, 32'h77});
    tick();
    set_info(2, 32'h99, 32'd9);
    clear_sig = 1'b1;
    valid_in = 4'b0100;
    tick();
    clear_sig = 1'b0;
    valid_in = '0;
    check("t6c_fields", 64'((out_free_mem == '0) && (out_pending_tasks == '0)), 64'd1);
    check("t6c_busy_wait", 64'(upstream_busy), 64'd1);
    check("t6c_addr_held", 64'(wr_addr), 64'(BASE));
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("t6c_idle", 64'(upstream_busy), 64'd0);
    check("t6c_thr", 64'(threshold_reached), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
